// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage; the future decode/control stage
// reuses the state encodings and bus widths.
package fetch_unit_pkg;

    localparam int INST_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    // Instructions are halfword aligned: force bit 0 of a target address low.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & {{(ADDR_W-1){1'b1}}, 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/ready bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [INST_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches one 16-bit
// instruction per request/ready handshake and hands it to the instruction
// register with a one-cycle write strobe. Stall holds a captured
// instruction; redirect reloads the PC and drops anything in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       PC_STEP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    fetch_unit_if.master      mem_bus,
    output logic [INST_W-1:0] ir_data,
    output logic              ir_write,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] inst_pc
);

    fetch_state_e      state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [INST_W-1:0] ir_data_q, ir_data_d;
    logic              fetch_done;

    // A fetch completes only while the request is actually on the bus.
    assign fetch_done = run_q && (state_q == ST_FETCH) && mem_bus.mem_ready;

    // Next-state and datapath decode; redirect overrides everything else.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        inst_pc_d = inst_pc_q;
        ir_data_d = ir_data_q;

        case (state_q)
            ST_FETCH: begin
                if (fetch_done) begin
                    ir_data_d = mem_bus.mem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + ADDR_W'(PC_STEP);
                    state_d   = stall ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_FETCH;
            ST_HOLD: begin
                if (!stall) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Data returned alongside a redirect is dropped: capture regs keep
        // their old contents and the FSM restarts fetching at the new target.
        if (redirect) begin
            state_d   = ST_FETCH;
            pc_d      = align_pc(redirect_addr);
            inst_pc_d = inst_pc_q;
            ir_data_d = ir_data_q;
        end
    end

    // State, PC and capture registers; run_q keeps the request low for the
    // first cycle after reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            inst_pc_q <= RESET_PC;
            ir_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            ir_data_q <= ir_data_d;
        end
    end

    assign mem_bus.mem_req  = run_q && (state_q == ST_FETCH);
    assign mem_bus.mem_addr = pc_q;
    assign ir_write         = (state_q == ST_ISSUE);
    assign ir_data          = ir_data_q;
    assign pc               = pc_q;
    assign inst_pc          = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (reset PC 0000 and FFFE)
// share stimulus; a behavioural model predicts every output each cycle, and
// directed sequences pin the model with hand-computed values.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        stall         = 1'b0;
    logic        redirect      = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        mem_ready     = 1'b0;
    logic [15:0] mem_rdata     = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();
    assign bus0.mem_ready = mem_ready;
    assign bus0.mem_rdata = mem_rdata;
    assign bus1.mem_ready = mem_ready;
    assign bus1.mem_rdata = mem_rdata;

    logic [15:0] ir_data0, pc0, inst_pc0, ir_data1, pc1, inst_pc1;
    logic        ir_write0, ir_write1;

    fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(2)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .mem_bus(bus0),
        .ir_data(ir_data0), .ir_write(ir_write0), .pc(pc0), .inst_pc(inst_pc0)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .PC_STEP(2)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .mem_bus(bus1),
        .ir_data(ir_data1), .ir_write(ir_write1), .pc(pc1), .inst_pc(inst_pc1)
    );

    logic [15:0] a_ir[2], a_pc[2], a_ipc[2], a_addr[2];
    logic        a_wr[2], a_req[2];
    assign a_ir[0] = ir_data0;   assign a_ir[1] = ir_data1;
    assign a_pc[0] = pc0;        assign a_pc[1] = pc1;
    assign a_ipc[0] = inst_pc0;  assign a_ipc[1] = inst_pc1;
    assign a_addr[0] = bus0.mem_addr; assign a_addr[1] = bus1.mem_addr;
    assign a_wr[0] = ir_write0;  assign a_wr[1] = ir_write1;
    assign a_req[0] = bus0.mem_req;   assign a_req[1] = bus1.mem_req;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: next fetch address, last captured instruction and its
    // address, whether an instruction is being handed over this cycle,
    // whether one is waiting for stall to drop, and whether the unit has
    // been out of reset for at least one edge.
    localparam logic [15:0] RPC [2] = '{16'h0000, 16'hFFFE};
    logic [15:0] m_pc[2], m_inst[2], m_ir[2];
    bit          m_issue[2], m_wait[2], m_live[2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_pc[i] = RPC[i]; m_inst[i] = RPC[i]; m_ir[i] = 16'h0000;
                m_issue[i] = 0; m_wait[i] = 0; m_live[i] = 0;
            end else begin
                if (redirect) begin
                    m_pc[i] = redirect_addr & 16'hFFFE;
                    m_issue[i] = 0; m_wait[i] = 0;
                end else if (m_issue[i]) begin
                    m_issue[i] = 0;
                end else if (m_wait[i]) begin
                    if (!stall) begin m_wait[i] = 0; m_issue[i] = 1; end
                end else if (m_live[i] && mem_ready) begin
                    m_ir[i]   = mem_rdata;
                    m_inst[i] = m_pc[i];
                    m_pc[i]   = m_pc[i] + 16'd2;
                    if (stall) m_wait[i] = 1; else m_issue[i] = 1;
                end
                m_live[i] = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Compare every instance against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_mem_req", i), 16'(a_req[i]),
                  16'(m_live[i] && !m_issue[i] && !m_wait[i]));
            check($sformatf("u%0d_mem_addr", i), a_addr[i], m_pc[i]);
            check($sformatf("u%0d_pc", i), a_pc[i], m_pc[i]);
            check($sformatf("u%0d_ir_write", i), 16'(a_wr[i]), 16'(m_issue[i]));
            check($sformatf("u%0d_ir_data", i), a_ir[i], m_ir[i]);
            check($sformatf("u%0d_inst_pc", i), a_ipc[i], m_inst[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rdy, input logic [15:0] rd, input logic st,
                         input logic rdr, input logic [15:0] ra);
        mem_ready = rdy; mem_rdata = rd; stall = st; redirect = rdr; redirect_addr = ra;
    endtask

    // Advance to the next cycle, apply inputs, stop mid-cycle for checks.
    task automatic cycle(input logic rdy, input logic [15:0] rd, input logic st,
                         input logic rdr, input logic [15:0] ra);
        @(posedge clk); #1;
        drive(rdy, rd, st, rdr, ra);
        @(negedge clk);
    endtask

    // Same, but also releases reset at the start of the cycle.
    task automatic release_cycle(input logic rdy, input logic [15:0] rd, input logic st);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(rdy, rd, st, 1'b0, 16'h0000);
        @(negedge clk);
    endtask

    task automatic expect0(input string tag, input logic req, input logic [15:0] addr,
                           input logic wr, input logic [15:0] ir, input logic [15:0] ipc,
                           input logic [15:0] p);
        check({tag, "_req"}, 16'(bus0.mem_req), 16'(req));
        check({tag, "_addr"}, bus0.mem_addr, addr);
        check({tag, "_wr"}, 16'(ir_write0), 16'(wr));
        check({tag, "_ir"}, ir_data0, ir);
        check({tag, "_ipc"}, inst_pc0, ipc);
        check({tag, "_pc"}, pc0, p);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1;
        expect0("rst0", 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        check("rst1_pc", pc1, 16'hFFFE);
        check("rst1_ipc", inst_pc1, 16'hFFFE);

        // Back-to-back fetches with memory always ready.
        release_cycle(1, 16'h1234, 0);
        expect0("c0", 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        cycle(1, 16'h1234, 0, 0, 16'h0000);
        expect0("c1", 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        check("c1_u1_addr", bus1.mem_addr, 16'hFFFE);
        cycle(1, 16'h5678, 0, 0, 16'h0000);
        expect0("c2", 0, 16'h0002, 1, 16'h1234, 16'h0000, 16'h0002);
        check("c2_u1_ipc", inst_pc1, 16'hFFFE);
        check("c2_u1_pc_wrap", pc1, 16'h0000);
        check("c2_u1_ir", ir_data1, 16'h1234);
        check("c2_model_pc0", m_pc[0], 16'h0002);
        check("c2_model_pc1", m_pc[1], 16'h0000);
        cycle(1, 16'h5678, 0, 0, 16'h0000);
        expect0("c3", 1, 16'h0002, 0, 16'h1234, 16'h0000, 16'h0002);
        cycle(0, 16'h0000, 0, 0, 16'h0000);
        expect0("c4", 0, 16'h0004, 1, 16'h5678, 16'h0002, 16'h0004);

        // Memory not ready for three cycles at 0004.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 16'h0000, 0, 0, 16'h0000);
            expect0("wait", 1, 16'h0004, 0, 16'h5678, 16'h0002, 16'h0004);
        end
        cycle(1, 16'h9ABC, 0, 0, 16'h0000);
        expect0("rdy", 1, 16'h0004, 0, 16'h5678, 16'h0002, 16'h0004);
        cycle(0, 16'h0000, 0, 0, 16'h0000);
        expect0("rdy_wr", 0, 16'h0006, 1, 16'h9ABC, 16'h0004, 16'h0006);

        // Stall across completion: hold, then one strobe after stall drops.
        cycle(1, 16'hABCD, 1, 0, 16'h0000);
        expect0("st_f", 1, 16'h0006, 0, 16'h9ABC, 16'h0004, 16'h0006);
        cycle(1, 16'hABCD, 1, 0, 16'h0000);
        expect0("hold1", 0, 16'h0008, 0, 16'hABCD, 16'h0006, 16'h0008);
        cycle(1, 16'hABCD, 1, 0, 16'h0000);
        expect0("hold2", 0, 16'h0008, 0, 16'hABCD, 16'h0006, 16'h0008);
        cycle(0, 16'h0000, 0, 0, 16'h0000);
        expect0("hold3", 0, 16'h0008, 0, 16'hABCD, 16'h0006, 16'h0008);
        cycle(0, 16'h0000, 1, 0, 16'h0000);
        expect0("unst", 0, 16'h0008, 1, 16'hABCD, 16'h0006, 16'h0008);

        // Redirect beats simultaneous ready and stall.
        cycle(1, 16'hDEAD, 1, 1, 16'h0101);
        expect0("rd_f", 1, 16'h0008, 0, 16'hABCD, 16'h0006, 16'h0008);
        cycle(1, 16'h1111, 0, 0, 16'h0000);
        expect0("rd_t", 1, 16'h0100, 0, 16'hABCD, 16'h0006, 16'h0100);
        // Redirect during the strobe cycle keeps that strobe.
        cycle(0, 16'h0000, 0, 1, 16'h0200);
        expect0("rd_iss", 0, 16'h0102, 1, 16'h1111, 16'h0100, 16'h0102);
        cycle(0, 16'h0000, 0, 0, 16'h0000);
        expect0("rd_t2", 1, 16'h0200, 0, 16'h1111, 16'h0100, 16'h0200);

        // Asynchronous reset mid-FETCH.
        #2 reset = 1'b0;
        #1;
        expect0("arst_f", 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        check("arst_f_u1_pc", pc1, 16'hFFFE);
        release_cycle(1, 16'h4242, 1);
        cycle(1, 16'h4242, 1, 0, 16'h0000);
        expect0("pre_h", 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        cycle(0, 16'h0000, 1, 0, 16'h0000);
        expect0("in_h", 0, 16'h0002, 0, 16'h4242, 16'h0000, 16'h0002);

        // Asynchronous reset mid-HOLD, then restart from RESET_PC.
        #2 reset = 1'b0;
        #1;
        expect0("arst_h", 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        release_cycle(1, 16'h7777, 0);
        cycle(1, 16'h7777, 0, 0, 16'h0000);
        expect0("rs1", 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        cycle(0, 16'h0000, 0, 0, 16'h0000);
        expect0("rs2", 0, 16'h0002, 1, 16'h7777, 16'h0000, 16'h0002);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            mem_ready     = ($urandom_range(0, 9) < 6);
            stall         = ($urandom_range(0, 9) < 3);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_addr = 16'($urandom);
            mem_rdata     = 16'($urandom);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
